// File: rtl/bus_source_decoder.sv
// bus_source_decoder
// Decodes a 5-bit bus-source code into a one-hot set of 24 bus-driver
// enables. A driver is held on for 1+hold_cycles cycles. With
// DEC_DEAD_CYCLE_EN defined, a zero cycle (GAP) separates consecutive drives
// so one driver is off before the next turns on. With the macro undefined,
// a new request can be accepted in the final drive cycle. The next driver
// then turns on in the following cycle with no zero cycle.
// Configuration macro: DEC_DEAD_CYCLE_EN
module bus_source_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_valid,
    input  logic [4:0]  sel_code,
    input  logic [2:0]  hold_cycles,
    output logic        sel_ready,
    output logic [23:0] src_en,
    output logic        drive_done,
    output logic        code_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] src_en_q, src_en_d;
    logic        drive_done_q, drive_done_d;
    logic        code_err_q, code_err_d;

    logic [23:0] code_onehot;
    logic        code_valid;
    logic        accept;

    // Codes 1..24 map to enable bit (code-1); every other code decodes to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 24; gi++) begin : g_dec
            assign code_onehot[gi] = (sel_code == 5'(gi + 1));
        end
    endgenerate

    assign code_valid = |code_onehot;

    // Ready is decoded from the current state only. The inputs never reach it.
`ifdef DEC_DEAD_CYCLE_EN
    assign sel_ready = (state_q == IDLE) || (state_q == GAP);
`else
    assign sel_ready = (state_q == IDLE) || ((state_q == DRIVE) && (cnt_q == 3'd0));
`endif

    assign accept = sel_valid && sel_ready;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        src_en_d     = src_en_q;
        drive_done_d = 1'b0;
        code_err_d   = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                state_d  = IDLE;
                src_en_d = 24'h0;
                cnt_d    = 3'd0;
            end
            DRIVE: begin
                if (cnt_q != 3'd0) begin
                    cnt_d        = cnt_q - 3'd1;
                    drive_done_d = (cnt_q == 3'd1);
                end else begin
                    src_en_d = 24'h0;
`ifdef DEC_DEAD_CYCLE_EN
                    state_d  = GAP;
`else
                    state_d  = IDLE;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                src_en_d = 24'h0;
                cnt_d    = 3'd0;
            end
        endcase

        // An accepted request overrides the above. accept can only be true in
        // states whose default successor is IDLE/GAP, so overriding is safe.
        if (accept) begin
            if (code_valid) begin
                state_d      = DRIVE;
                src_en_d     = code_onehot;
                cnt_d        = hold_cycles;
                drive_done_d = (hold_cycles == 3'd0);
            end else begin
                state_d      = IDLE;
                src_en_d     = 24'h0;
                cnt_d        = 3'd0;
                code_err_d   = 1'b1;
            end
        end
    end

    // State and output registers. Reset wins over any acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            src_en_q     <= 24'h0;
            drive_done_q <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            src_en_q     <= src_en_d;
            drive_done_q <= drive_done_d;
            code_err_q   <= code_err_d;
        end
    end

    assign src_en     = src_en_q;
    assign drive_done = drive_done_q;
    assign code_err   = code_err_q;

endmodule
